// File: rtl/dest_reg_pipe.sv
// Destination-register select and EX/MEM/WB shadow pipeline with per-stage RAW match flags.
// Optional: define DEST_PIPE_LINK_EN to add link_req, which forces a write of the all-ones register.
module dest_reg_pipe #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1,
  parameter int DEPTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] src_flat,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_wen,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
`ifdef DEST_PIPE_LINK_EN
  input  logic                      link_req,
`endif
  output logic [DEPTH*ADDR_W-1:0]   stage_addr_flat,
  output logic [DEPTH-1:0]          stage_wen,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic                      wb_wen,
  output logic [DEPTH-1:0]          hazard_rs,
  output logic [DEPTH-1:0]          hazard_rt
);

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_wen;
  logic [ADDR_W-1:0] stage_addr [DEPTH];
  logic [DEPTH-1:0]  stage_wen_q;

  // An out-of-range select matches no candidate, leaving addr 0 and therefore no write.
  always_comb begin
    cap_addr = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_addr = src_flat[k*ADDR_W +: ADDR_W];
      end
    end
    cap_wen = in_wen && (cap_addr != '0);
`ifdef DEST_PIPE_LINK_EN
    if (link_req) begin
      cap_addr = '1;
      cap_wen  = 1'b1;
    end
`endif
  end

  // Flush only ever touches stage 0; stall freezes the older stages even during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_addr[i] <= '0;
      end
      stage_wen_q <= '0;
    end else begin
      if (flush) begin
        stage_addr[0]  <= '0;
        stage_wen_q[0] <= 1'b0;
      end else if (!stall) begin
        stage_addr[0]  <= cap_addr;
        stage_wen_q[0] <= cap_wen;
      end
      if (!stall) begin
        for (int i = 1; i < DEPTH; i++) begin
          stage_addr[i]  <= stage_addr[i-1];
          stage_wen_q[i] <= stage_wen_q[i-1];
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      assign stage_addr_flat[g*ADDR_W +: ADDR_W] = stage_addr[g];
      assign hazard_rs[g] = stage_wen_q[g] && (stage_addr[g] == rs_addr) && (rs_addr != '0);
      assign hazard_rt[g] = stage_wen_q[g] && (stage_addr[g] == rt_addr) && (rt_addr != '0);
    end
  endgenerate

  assign stage_wen = stage_wen_q;
  assign wb_addr   = stage_addr[DEPTH-1];
  assign wb_wen    = stage_wen_q[DEPTH-1];

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed, table-driven bench for dest_reg_pipe (ADDR_W=5, NUM_SRC=2, DEPTH=3).
// Link-request checks are included only when DEST_PIPE_LINK_EN is defined.
module tb_dest_reg_pipe;

  logic        clk;
  logic        rst_n;
  logic [9:0]  src_flat;
  logic        sel;
  logic        in_wen;
  logic        stall;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
`ifdef DEST_PIPE_LINK_EN
  logic        link_req;
`endif
  logic [14:0] stage_addr_flat;
  logic [2:0]  stage_wen;
  logic [4:0]  wb_addr;
  logic        wb_wen;
  logic [2:0]  hazard_rs;
  logic [2:0]  hazard_rt;

  int checks = 0;
  int errors = 0;

  dest_reg_pipe #(.ADDR_W(5), .NUM_SRC(2), .SEL_W(1), .DEPTH(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_flat        (src_flat),
    .sel             (sel),
    .in_wen          (in_wen),
    .stall           (stall),
    .flush           (flush),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
`ifdef DEST_PIPE_LINK_EN
    .link_req        (link_req),
`endif
    .stage_addr_flat (stage_addr_flat),
    .stage_wen       (stage_wen),
    .wb_addr         (wb_addr),
    .wb_wen          (wb_wen),
    .hazard_rs       (hazard_rs),
    .hazard_rt       (hazard_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] src0;
    logic [4:0] src1;
    logic       sel;
    logic       in_wen;
    logic       stall;
    logic       flush;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [2:0] wen;
    logic [2:0] hrs;
    logic [2:0] hrt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [2:0] wen,
                              input logic [2:0] hrs, input logic [2:0] hrt);
    check({tag, " stage_addr_flat"}, 32'(stage_addr_flat), 32'({a2, a1, a0}));
    check({tag, " stage_wen"},       32'(stage_wen),       32'(wen));
    check({tag, " wb_addr"},         32'(wb_addr),         32'(a2));
    check({tag, " wb_wen"},          32'(wb_wen),          32'(wen[2]));
    check({tag, " hazard_rs"},       32'(hazard_rs),       32'(hrs));
    check({tag, " hazard_rt"},       32'(hazard_rt),       32'(hrt));
  endtask

  task automatic apply_stimulus(input vec_t v);
    src_flat = {v.src1, v.src0};
    sel      = v.sel;
    in_wen   = v.in_wen;
    stall    = v.stall;
    flush    = v.flush;
    rs_addr  = v.rs;
    rt_addr  = v.rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fields: src0 src1 sel wen stall flush rs rt | s0 s1 s2 wen[2:0] hz_rs hz_rt
    vecs[0]  = '{5'd8,  5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 5'd0, 5'd17, 5'd0,  5'd0,  3'b001, 3'b001, 3'b000};
    vecs[1]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0, 5'd0,  5'd17, 5'd0,  3'b010, 3'b010, 3'b000};
    vecs[2]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0, 5'd0,  5'd0,  5'd17, 3'b100, 3'b100, 3'b000};
    vecs[3]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0, 5'd0,  5'd0,  5'd0,  3'b000, 3'b000, 3'b000};
    vecs[4]  = '{5'd0,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  5'd0,  5'd0,  3'b000, 3'b000, 3'b000};
    vecs[5]  = '{5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 5'd7,  5'd0,  5'd0,  3'b001, 3'b000, 3'b000};
    vecs[6]  = '{5'd3,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 5'd6,  5'd7,  5'd0,  3'b011, 3'b000, 3'b000};
    vecs[7]  = '{5'd5,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 5'd6,  5'd7, 5'd5,  5'd6,  5'd7,  3'b111, 3'b010, 3'b100};
    vecs[8]  = '{5'd9,  5'd2,  1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  5'd7, 5'd5,  5'd6,  5'd7,  3'b111, 3'b001, 3'b100};
    vecs[9]  = '{5'd9,  5'd2,  1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  5'd0, 5'd0,  5'd6,  5'd7,  3'b110, 3'b010, 3'b000};
    vecs[10] = '{5'd9,  5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 5'd6,  5'd0, 5'd0,  5'd0,  5'd6,  3'b100, 3'b100, 3'b000};
    vecs[11] = '{5'd1,  5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 5'd0, 5'd12, 5'd0,  5'd0,  3'b000, 3'b000, 3'b000};
    vecs[12] = '{5'd4,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 5'd4,  5'd12, 5'd0,  3'b001, 3'b000, 3'b000};
    vecs[13] = '{5'd9,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 5'd9,  5'd4,  5'd12, 3'b011, 3'b000, 3'b000};
    vecs[14] = '{5'd9,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  5'd4, 5'd9,  5'd9,  5'd4,  3'b111, 3'b011, 3'b100};
    vecs[15] = '{5'd2,  5'd1,  1'b0, 1'b1, 1'b1, 1'b0, 5'd9,  5'd9, 5'd9,  5'd9,  5'd4,  3'b111, 3'b011, 3'b011};

    rst_n    = 1'b0;
    src_flat = '0;
    sel      = 1'b0;
    in_wen   = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    rs_addr  = '0;
    rt_addr  = '0;
`ifdef DEST_PIPE_LINK_EN
    link_req = 1'b0;
`endif
    #12;
    check_output("reset", 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].a2,
                   vecs[i].wen, vecs[i].hrs, vecs[i].hrt);
    end

    // Asynchronous reset between edges while stall and flush are both active.
    stall   = 1'b1;
    flush   = 1'b1;
    rs_addr = 5'd9;
    rt_addr = 5'd4;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 3'b000);
    @(posedge clk);
    #1;
    check_output("reset_held", 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;

    // Fresh entry after reset release reaches writeback three edges later.
    apply_stimulus('{5'd21, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd21, 5'd21, 5'd21, 5'd0, 5'd0, 3'b001, 3'b001, 3'b001});
    check_output("post_reset_s0", 5'd21, 5'd0, 5'd0, 3'b001, 3'b001, 3'b001);
    apply_stimulus('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd21, 5'd21, 5'd0, 5'd21, 5'd0, 3'b010, 3'b010, 3'b010});
    apply_stimulus('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd21, 5'd21, 5'd0, 5'd0, 5'd21, 3'b100, 3'b100, 3'b100});
    check_output("post_reset_wb", 5'd0, 5'd0, 5'd21, 3'b100, 3'b100, 3'b100);

`ifdef DEST_PIPE_LINK_EN
    link_req = 1'b1;
    apply_stimulus('{5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd0, 3'b001, 3'b001, 3'b000});
    check_output("link", 5'd31, 5'd0, 5'd0, 3'b001, 3'b001, 3'b000);
    apply_stimulus('{5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd0, 5'd0, 5'd31, 5'd0, 3'b010, 3'b010, 3'b000});
    check_output("link_flush", 5'd0, 5'd31, 5'd0, 3'b010, 3'b010, 3'b000);
    link_req = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
